dense_output_layer: RTL
=======================

Name: dense_output_layer

Overview:
- Final fully-connected layer of the digit classifier.
- Streams in one frame of N_IN signed activations, then runs a serial MAC against an external weight/bias memory.
- Produces N_OUT signed 32-bit class scores plus a valid flag, which drive the argmax comparator directly downstream.
- Uses one multiplier, time-shared across all neurons.

Parameters:
- N_IN, 32, activations per frame
- N_OUT, 10, output neurons (class scores)
- DATA_W, 32, activation/weight/score width (signed)
- FRAC, 8, fixed-point fraction bits of activations and weights
- ADDR_W, $clog2(N_OUT*(N_IN+1)), weight memory address width

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-low
- in_valid  input  1  activation beat valid
- in_ready  output  1  block accepts activation beat
- in_data  input  DATA_W  signed activation
- w_rd  output  1  weight memory read strobe
- w_addr  output  ADDR_W  weight memory address
- w_data  input  DATA_W  signed weight/bias, valid exactly 1 cycle after w_rd
- scores  output  N_OUT x DATA_W  unpacked array of signed (int) scores, index = class
- out_valid  output  1  scores hold a complete, stable result

Behaviour:
- Reset (rst==0 at clock edge): state=LOAD, counters=0, accumulator=0, all scores=0, out_valid=0, w_rd=0, in_ready=0 during reset. in_ready=1 the first cycle after rst returns high. Reset mid-frame or mid-MAC aborts the operation; partial results are discarded.
- Memory map: address j*(N_IN+1)+i holds weight(neuron j, input i) for i<N_IN; address j*(N_IN+1)+N_IN holds bias j (already in FRAC format).
- FSM states: LOAD, MAC, DRAIN.
- LOAD:
  - in_ready=1. A beat is accepted when in_valid&&in_ready; act[cnt]<=in_data, cnt++.
  - Gaps in in_valid are allowed.
  - When beat N_IN-1 is accepted, go to MAC and drop in_ready on the next cycle.
  - Acceptance of beat 0 clears out_valid.
- MAC:
  - in_ready=0; in_valid is ignored and no data is consumed.
  - Issues one read per cycle, w_rd=1, over addresses 0 .. N_OUT*(N_IN+1)-1 in order. One cycle later the returned term is accumulated:
    - weight term: acc += (w_data*act[i]) >>> FRAC, using a full 2*DATA_W signed product and arithmetic shift (floor).
    - bias term: acc += sign-extended w_data.
  - Accumulator width is 2*DATA_W+8; no intermediate overflow.
  - After the last issued address, go to DRAIN.
- Neuron write-back: on the edge that accumulates neuron j's bias term, scores[j] is written with the saturated sum and acc is cleared.
  - Saturation: >2^31-1 gives 0x7FFFFFFF; <-2^31 gives 0x80000000.
  - Scores not yet rewritten keep their previous values.
- DRAIN:
  - w_rd=0. Completes the final accumulation and write-back.
  - On the next edge set out_valid=1 and return to LOAD.
- Latency: out_valid is 1 exactly N_OUT*(N_IN+1)+2 cycles after the edge that accepts the last activation.
- out_valid is a level signal: it stays high in LOAD until beat 0 of the next frame is accepted. While out_valid=1, scores are stable.
- Beat 0 accepted on the same edge DRAIN sets out_valid: not possible, because in_ready=0 in DRAIN.
- w_addr is don't-care when w_rd=0; the implementation drives 0.

Test Plan:
- Reset mid-MAC:
  - Stimulus: N_IN=4, rst=0 for 2 cycles during the 20th MAC cycle.
  - Required: scores all 0, out_valid=0, w_rd=0; in_ready=1 one cycle after rst=1; the next full frame produces correct scores.
- Basic dot product:
  - Stimulus: N_IN=4, acts all 256 (1.0), weights of neuron j all j*256, biases 0.
  - Required: scores[j]=1024*j; out_valid rises exactly 52 cycles after the last beat accepted.
- Bias and floor rounding:
  - Stimulus: acts all -1, weights all 1, bias_j=-100+j.
  - Required: each product gives -1; scores[j]=-104+j.
- Saturation:
  - Stimulus: acts 0x7FFF0000, neuron 0 weights 0x7FFF0000, neuron 1 weights 0x80010000.
  - Required: scores[0]=0x7FFFFFFF, scores[1]=0x80000000; other neurons unaffected.
- Stream handshake:
  - Stimulus: in_valid toggled 1,0,1,0…, then in_valid held 1 during MAC with junk data.
  - Required: results identical to the gap-free case; in_ready=0 for the whole MAC/DRAIN window; no extra beat consumed.
- Back-to-back frames:
  - Stimulus: frame 2 starts 3 cycles after out_valid rises.
  - Required: out_valid falls on the edge accepting frame 2 beat 0; scores for frame 1 are unchanged until frame 2's neuron 0 write-back.

Source files
------------

// File: rtl/dense_output_layer.sv
// Final fully-connected layer: loads one frame of activations, then runs a serial MAC
// against an external weight/bias memory and produces saturated per-class scores.
module dense_output_layer #(
  parameter int N_IN   = 32,
  parameter int N_OUT  = 10,
  parameter int DATA_W = 32,
  parameter int FRAC   = 8,
  parameter int ADDR_W = $clog2(N_OUT*(N_IN+1))
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     w_rd,
  output logic [ADDR_W-1:0]        w_addr,
  input  logic signed [DATA_W-1:0] w_data,
  output logic signed [DATA_W-1:0] scores [N_OUT],
  output logic                     out_valid
);

  localparam int N_WORDS = N_OUT*(N_IN+1);
  localparam int IW      = $clog2(N_IN+1);
  localparam int AW      = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int JW      = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int ACC_W   = 2*DATA_W + 8;

  typedef enum logic [1:0] {LOAD, MAC, DRAIN} state_t;

  state_t                    state;
  logic [AW-1:0]             cnt;
  logic signed [DATA_W-1:0]  act [N_IN];
  logic [IW-1:0]             iss_i, p_i;
  logic [JW-1:0]             iss_j, p_j;
  logic                      p_valid;
  logic signed [ACC_W-1:0]   acc, acc_next;
  logic signed [DATA_W-1:0]  act_sel, sat_val;
  logic signed [2*DATA_W-1:0] w_ext, a_ext, prod, term;
  logic                      p_bias, accept, overflow;

  assign accept = (state == LOAD) && in_valid && in_ready;
  assign p_bias = (p_i == IW'(N_IN));

  // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    act_sel = '0;
    if (p_i < IW'(N_IN)) act_sel = act[p_i[AW-1:0]];
    w_ext = {{DATA_W{w_data[DATA_W-1]}}, w_data};
    a_ext = {{DATA_W{act_sel[DATA_W-1]}}, act_sel};
    prod  = w_ext * a_ext;
    term  = prod >>> FRAC;
    if (p_bias) acc_next = acc + {{(ACC_W-DATA_W){w_data[DATA_W-1]}}, w_data};
    else        acc_next = acc + {{(ACC_W-2*DATA_W){term[2*DATA_W-1]}}, term};
    // The sum fits in DATA_W only if all bits above the score's sign bit agree with it.
    overflow = !((&acc_next[ACC_W-1:DATA_W-1]) || !(|acc_next[ACC_W-1:DATA_W-1]));
    sat_val  = acc_next[DATA_W-1:0];
    if (overflow) sat_val = acc_next[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                              : {1'b0, {(DATA_W-1){1'b1}}};
  end

  // NOTE: the activation buffer has no reset; every entry is rewritten before MAC reads it.
  always_ff @(posedge clk) begin
    if (accept) act[cnt] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= LOAD;
      cnt       <= '0;
      iss_i     <= '0;
      iss_j     <= '0;
      p_valid   <= 1'b0;
      p_i       <= '0;
      p_j       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      w_rd      <= 1'b0;
      w_addr    <= '0;
      in_ready  <= 1'b0;
      for (int j = 0; j < N_OUT; j++) scores[j] <= '0;
    end else begin
      // Read data returns one cycle after the strobe; track which term it belongs to.
      p_valid <= w_rd;
      p_i     <= iss_i;
      p_j     <= iss_j;
      if (p_valid) begin
        if (p_bias) begin
          scores[p_j] <= sat_val;
          acc         <= '0;
        end else begin
          acc <= acc_next;
        end
      end

      case (state)
        LOAD: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (cnt == '0) out_valid <= 1'b0;
            if (cnt == AW'(N_IN-1)) begin
              cnt      <= '0;
              in_ready <= 1'b0;
              state    <= MAC;
              w_rd     <= 1'b1;
              w_addr   <= '0;
              iss_i    <= '0;
              iss_j    <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        MAC: begin
          if (w_addr == ADDR_W'(N_WORDS-1)) begin
            w_rd   <= 1'b0;
            w_addr <= '0;
            state  <= DRAIN;
          end else begin
            w_addr <= w_addr + 1'b1;
            if (iss_i == IW'(N_IN)) begin
              iss_i <= '0;
              iss_j <= iss_j + 1'b1;
            end else begin
              iss_i <= iss_i + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!p_valid) begin
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
            state     <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
